// File: rtl/jelly2_ram_accumulator_if.sv
// Increment stream into the RAM accumulator: one (addr, data) beat per valid & ready cycle.
interface jelly2_ram_accumulator_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    // Beat transfers when s_valid & s_ready; s_ready never depends on s_valid.
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_addr, output s_data, output s_valid, input s_ready);
    modport slave  (input s_addr, input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/jelly2_ram_accumulator.sv
// Read-modify-write accumulator for a dual-port auto-clear RAM: reads on port 0,
// writes L cycles later on port 1, with write-history forwarding for back-to-back hits.
module jelly2_ram_accumulator #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int SATURATE     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  busy,
    jelly2_ram_accumulator_if.slave s,
    output logic [DATA_WIDTH-1:0] ram_clear_din,
    output logic                  ram_clear_start,
    input  logic                  ram_clear_busy,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_dout,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_din,
    output logic [1:0]            dbg_state
);
    localparam int L = READ_LATENCY;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  clr_first_q;
    logic                  accept;
    logic                  stg_any;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] old_data;
    logic [DATA_WIDTH:0]   sum_full;
    logic [DATA_WIDTH-1:0] sum_data;

    logic                  stg_vld_q  [1:L];
    logic [ADDR_WIDTH-1:0] stg_addr_q [1:L];
    logic [DATA_WIDTH-1:0] stg_data_q [1:L];
    logic                  h_vld_q    [1:L];
    logic [ADDR_WIDTH-1:0] h_addr_q   [1:L];
    logic [DATA_WIDTH-1:0] h_data_q   [1:L];

    assign s.s_ready     = (state_q == ST_RUN) & ~clear_start & ~reset;
    assign accept        = s.s_valid & s.s_ready;
    assign ram_rd_en     = accept;
    assign ram_rd_addr   = s.s_addr;
    assign ram_clear_din = '0;
    assign dbg_state     = state_q;

    always_comb begin
        stg_any = 1'b0;
        for (int k = 1; k <= L; k++) begin
            stg_any = stg_any | stg_vld_q[k];
        end
    end

    assign busy = (state_q != ST_RUN) | stg_any;

    // History h[k] covers writes from the read cycle onwards that the RAM read missed;
    // walking k downwards lets the newest matching write win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = L; k >= 1; k--) begin
            if (h_vld_q[k] && (h_addr_q[k] == stg_addr_q[L])) begin
                fwd_hit  = 1'b1;
                fwd_data = h_data_q[k];
            end
        end
    end

    assign old_data = fwd_hit ? fwd_data : ram_rd_dout;
    assign sum_full = {1'b0, old_data} + {1'b0, stg_data_q[L]};

    always_comb begin
        sum_data = sum_full[DATA_WIDTH-1:0];
        if ((SATURATE != 0) && sum_full[DATA_WIDTH]) begin
            sum_data = '1;
        end
    end

    assign ram_wr_en   = stg_vld_q[L] & ~reset;
    assign ram_wr_addr = stg_addr_q[L];
    assign ram_wr_din  = sum_data;

    always_comb begin
        state_d         = state_q;
        ram_clear_start = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (clear_start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!stg_any) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                ram_clear_start = ~reset;
                state_d         = ST_CLEAR;
            end
            ST_CLEAR: begin
                // The RAM raises its busy one cycle after the pulse, so hold at least one cycle.
                if (!clr_first_q && !ram_clear_busy) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            clr_first_q <= 1'b0;
            for (int k = 1; k <= L; k++) begin
                stg_vld_q[k] <= 1'b0;
                h_vld_q[k]   <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            clr_first_q  <= (state_q == ST_ISSUE);
            stg_vld_q[1] <= accept;
            h_vld_q[1]   <= ram_wr_en;
            for (int k = 2; k <= L; k++) begin
                stg_vld_q[k] <= stg_vld_q[k-1];
                h_vld_q[k]   <= h_vld_q[k-1];
            end
            if (state_q == ST_ISSUE) begin
                for (int k = 1; k <= L; k++) begin
                    h_vld_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        stg_addr_q[1] <= s.s_addr;
        stg_data_q[1] <= s.s_data;
        h_addr_q[1]   <= stg_addr_q[L];
        h_data_q[1]   <= sum_data;
        for (int k = 2; k <= L; k++) begin
            stg_addr_q[k] <= stg_addr_q[k-1];
            stg_data_q[k] <= stg_data_q[k-1];
            h_addr_q[k]   <= h_addr_q[k-1];
            h_data_q[k]   <= h_data_q[k-1];
        end
    end
endmodule
